// File: rtl/mem_err_pkg.sv
// Shared state encoding and default sizing for the memory error monitor.
package mem_err_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DEGRADED = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam int DEF_CNT_WIDTH   = 8;
    localparam int DEF_CORR_THRESH = 4;

endpackage

// File: rtl/err_sat_cnt.sv
// Saturating event counter with synchronous clear; clear wins over hold, increment still applies.
// Latency: 1 cycle from inc/clr to cnt.
// Backpressure: none, one increment accepted every cycle.
module err_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= WIDTH'(inc);
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_err_monitor.sv
// Per-memory ECC error counters with NORMAL/DEGRADED/FAULT health state and level interrupt.
// Latency: 1 cycle from sampled event to counters, state, alarms and irq.
// Backpressure: none, error flags are sampled every cycle.
module mem_err_monitor
    import mem_err_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int CORR_THRESH = DEF_CORR_THRESH,
    localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           err_detected,
    input  logic [NUM_SRC-1:0]           err_corrected,
    input  logic                         clr_cnt,
    input  logic                         irq_ack,
    output logic                         irq,
    output logic                         alarm_minor,
    output logic                         alarm_major,
    output logic [SRC_W-1:0]             fault_src,
    output logic [NUM_SRC*CNT_WIDTH-1:0] corr_cnt,
    output logic [NUM_SRC*CNT_WIDTH-1:0] uncorr_cnt
);

    localparam logic [CNT_WIDTH-1:0] THRESH    = CNT_WIDTH'(CORR_THRESH);
    localparam logic [CNT_WIDTH-1:0] THRESH_M1 = CNT_WIDTH'(CORR_THRESH - 1);

    state_t             state;
    logic [NUM_SRC-1:0] corr_evt;
    logic [NUM_SRC-1:0] uncorr_evt;
    logic [NUM_SRC-1:0] corr_hit;
    logic [SRC_W-1:0]   first_src;
    logic [CNT_WIDTH-1:0] corr_q   [NUM_SRC];
    logic [CNT_WIDTH-1:0] uncorr_q [NUM_SRC];

    assign corr_evt   = err_detected & err_corrected;
    assign uncorr_evt = err_detected & ~err_corrected;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        err_sat_cnt #(.WIDTH(CNT_WIDTH)) u_corr (
            .clk (clk),
            .rst (rst),
            .clr (clr_cnt),
            .inc (corr_evt[gi]),
            .cnt (corr_q[gi])
        );

        err_sat_cnt #(.WIDTH(CNT_WIDTH)) u_uncorr (
            .clk (clk),
            .rst (rst),
            .clr (clr_cnt),
            .inc (uncorr_evt[gi]),
            .cnt (uncorr_q[gi])
        );

        assign corr_cnt[gi*CNT_WIDTH +: CNT_WIDTH]   = corr_q[gi];
        assign uncorr_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = uncorr_q[gi];

        // Next counter value reaches threshold; threshold never exceeds the saturation value.
        assign corr_hit[gi] = clr_cnt ? (corr_evt[gi] && (CORR_THRESH == 1))
                                      : ((corr_q[gi] >= THRESH) ||
                                         (corr_evt[gi] && (corr_q[gi] == THRESH_M1)));
    end

    always_comb begin
        first_src = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (uncorr_evt[i]) begin
                first_src = SRC_W'(i);
            end
        end
    end

    // An acknowledge drops irq unless a state entry later in this block re-raises it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NORMAL;
            irq         <= 1'b0;
            alarm_minor <= 1'b0;
            alarm_major <= 1'b0;
            fault_src   <= '0;
        end else begin
            if (irq_ack) begin
                irq <= 1'b0;
            end
            case (state)
                NORMAL, DEGRADED: begin
                    if (|uncorr_evt) begin
                        state       <= FAULT;
                        fault_src   <= first_src;
                        alarm_major <= 1'b1;
                        alarm_minor <= 1'b0;
                        irq         <= 1'b1;
                    end else if (state == NORMAL && (|corr_hit)) begin
                        state       <= DEGRADED;
                        alarm_minor <= 1'b1;
                        irq         <= 1'b1;
                    end else if (state == DEGRADED && clr_cnt && !(|corr_hit)) begin
                        state       <= NORMAL;
                        alarm_minor <= 1'b0;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state       <= NORMAL;
                    alarm_minor <= 1'b0;
                    alarm_major <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_err_monitor.sv
// Directed bench for mem_err_monitor at default parameters (2 sources, 8-bit counters, threshold 4).
module tb_mem_err_monitor;

    logic        clk;
    logic        rst;
    logic [1:0]  err_detected;
    logic [1:0]  err_corrected;
    logic        clr_cnt;
    logic        irq_ack;
    logic        irq;
    logic        alarm_minor;
    logic        alarm_major;
    logic [0:0]  fault_src;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mem_err_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .err_detected  (err_detected),
        .err_corrected (err_corrected),
        .clr_cnt       (clr_cnt),
        .irq_ack       (irq_ack),
        .irq           (irq),
        .alarm_minor   (alarm_minor),
        .alarm_major   (alarm_major),
        .fault_src     (fault_src),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, sample after the edge, then return inputs to idle.
    task automatic drive(input logic [1:0] det, input logic [1:0] cor,
                         input logic clr, input logic ack);
        err_detected  = det;
        err_corrected = cor;
        clr_cnt       = clr;
        irq_ack       = ack;
        @(posedge clk);
        #1;
        err_detected  = 2'b00;
        err_corrected = 2'b00;
        clr_cnt       = 1'b0;
        irq_ack       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b11, 2'b01, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_irq"},    32'(irq), 0);
        chk({tag, "_minor"},  32'(alarm_minor), 0);
        chk({tag, "_major"},  32'(alarm_major), 0);
        chk({tag, "_src"},    32'(fault_src), 0);
        chk({tag, "_corr"},   32'(corr_cnt), 0);
        chk({tag, "_uncorr"}, 32'(uncorr_cnt), 0);
    endtask

    initial begin
        rst = 1'b1;
        err_detected  = 2'b11;
        err_corrected = 2'b01;
        clr_cnt = 1'b1;
        irq_ack = 1'b0;
        @(posedge clk);
        drive(2'b11, 2'b01, 1'b1, 1'b1);
        rst = 1'b0;
        chk_all_zero("reset");

        // Threshold crossing on source 0
        for (int i = 0; i < 3; i++) drive(2'b01, 2'b01, 1'b0, 1'b0);
        chk("corr0_3", 32'(corr_cnt[7:0]), 3);
        chk("minor_below", 32'(alarm_minor), 0);
        chk("irq_below", 32'(irq), 0);
        drive(2'b01, 2'b01, 1'b0, 1'b0);
        chk("corr0_4", 32'(corr_cnt[7:0]), 4);
        chk("minor_deg", 32'(alarm_minor), 1);
        chk("irq_deg", 32'(irq), 1);
        chk("major_deg", 32'(alarm_major), 0);

        drive(2'b00, 2'b00, 1'b0, 1'b1);
        chk("irq_acked", 32'(irq), 0);
        chk("minor_after_ack", 32'(alarm_minor), 1);
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        chk("irq_ack_idle", 32'(irq), 0);

        // Clear together with a correctable event while DEGRADED
        drive(2'b01, 2'b01, 1'b1, 1'b0);
        chk("clr_evt_corr0", 32'(corr_cnt[7:0]), 1);
        chk("clr_evt_minor", 32'(alarm_minor), 0);
        chk("clr_evt_irq", 32'(irq), 0);

        // Corrected flag without detected flag is ignored
        drive(2'b00, 2'b11, 1'b0, 1'b0);
        chk("ign_corr", 32'(corr_cnt), 1);
        chk("ign_uncorr", 32'(uncorr_cnt), 0);

        // Back to DEGRADED, then ack coincident with entry into FAULT
        for (int i = 0; i < 3; i++) drive(2'b01, 2'b01, 1'b0, 1'b0);
        chk("redeg_minor", 32'(alarm_minor), 1);
        chk("redeg_irq", 32'(irq), 1);
        drive(2'b10, 2'b00, 1'b0, 1'b1);
        chk("ackfault_irq", 32'(irq), 1);
        chk("ackfault_major", 32'(alarm_major), 1);
        chk("ackfault_minor", 32'(alarm_minor), 0);
        chk("ackfault_src", 32'(fault_src), 1);
        chk("ackfault_uncorr1", 32'(uncorr_cnt[15:8]), 1);

        drive(2'b00, 2'b00, 1'b1, 1'b0);
        chk("fclr_corr", 32'(corr_cnt), 0);
        chk("fclr_uncorr", 32'(uncorr_cnt), 0);
        chk("fclr_major", 32'(alarm_major), 1);
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        chk("fault_ack", 32'(irq), 0);
        drive(2'b01, 2'b00, 1'b0, 1'b0);
        chk("fault_again_irq", 32'(irq), 0);
        chk("fault_src_held", 32'(fault_src), 1);
        chk("fault_again_uncorr0", 32'(uncorr_cnt[7:0]), 1);

        // Reset mid-stream with events present
        do_reset();
        chk_all_zero("midrst");

        // Single uncorrectable on source 1 from NORMAL
        drive(2'b10, 2'b00, 1'b0, 1'b0);
        chk("u1_major", 32'(alarm_major), 1);
        chk("u1_src", 32'(fault_src), 1);
        chk("u1_uncorr1", 32'(uncorr_cnt[15:8]), 1);
        chk("u1_irq", 32'(irq), 1);
        drive(2'b00, 2'b00, 1'b1, 1'b0);
        chk("u1_clr_major", 32'(alarm_major), 1);
        chk("u1_clr_uncorr1", 32'(uncorr_cnt[15:8]), 0);

        // FAULT wins over a same-cycle threshold crossing
        do_reset();
        for (int i = 0; i < 3; i++) drive(2'b01, 2'b01, 1'b0, 1'b0);
        drive(2'b11, 2'b01, 1'b0, 1'b0);
        chk("prio_major", 32'(alarm_major), 1);
        chk("prio_minor", 32'(alarm_minor), 0);
        chk("prio_src", 32'(fault_src), 1);
        chk("prio_corr0", 32'(corr_cnt[7:0]), 4);

        // Both sources uncorrectable: lowest index captured
        do_reset();
        drive(2'b11, 2'b00, 1'b0, 1'b0);
        chk("both_src", 32'(fault_src), 0);
        chk("both_major", 32'(alarm_major), 1);
        chk("both_uncorr", 32'(uncorr_cnt), 32'h0101);

        // Saturation
        do_reset();
        for (int i = 0; i < 300; i++) drive(2'b01, 2'b01, 1'b0, 1'b0);
        chk("sat_corr0", 32'(corr_cnt[7:0]), 255);
        chk("sat_corr1", 32'(corr_cnt[15:8]), 0);
        chk("sat_minor", 32'(alarm_minor), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
